// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch unit: FSM states, buffered fetch entry, PC increment.
// The entry widths here set the widths the top level's PC_W and INST_W must match.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    localparam int ENTRY_PC_W   = 32;
    localparam int ENTRY_INST_W = 32;
    localparam int PC_INC       = 4;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0]   pc;
        logic [ENTRY_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular buffer of fetched {pc, inst} entries feeding decode; clear empties it in one cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               din,
    input  logic                       pop,
    input  logic                       clear,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch controller: one blocking icache request at a time, results buffered for decode.
// Optional IFETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc_i,
    output logic [PC_W-1:0]   pc_next_o,
    output logic              pc_we_o,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    output logic              icache_req_o,
    output logic [PC_W-1:0]   icache_addr_o,
    input  logic              icache_ack_i,
    input  logic              icache_rvalid_i,
    input  logic [INST_W-1:0] icache_rdata_i,
    output logic              id_valid_o,
    output logic [PC_W-1:0]   id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    input  logic              id_ready_i
);

    state_t                 state;
    logic [PC_W-1:0]        req_pc;
    logic                   outstanding;
    logic                   credit;
    logic                   fire;
    logic                   rsp_take;
    logic                   push;
    logic                   pop;
    fetch_entry_t           din;
    fetch_entry_t           head;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;

    // An in-flight request reserves a buffer slot so its response can always be stored.
    assign outstanding   = (state != S_REQ);
    assign credit        = (int'(count) + int'(outstanding)) < DEPTH;
    assign icache_req_o  = rst_n & (state == S_REQ) & credit & ~redirect_i;
    assign icache_addr_o = pc_i;
    assign fire          = icache_req_o & icache_ack_i;
    assign rsp_take      = (state == S_WAIT) & icache_rvalid_i & ~redirect_i;

    assign din.pc   = req_pc;
    assign din.inst = icache_rdata_i;
    assign pop      = id_valid_o & id_ready_i;

`ifdef IFETCH_BYPASS_EN
    logic bypass;
    assign bypass     = empty & rsp_take;
    assign push       = rsp_take & ~(bypass & id_ready_i);
    assign id_valid_o = ~empty | bypass;
    assign id_pc_o    = bypass ? req_pc : head.pc;
    assign id_inst_o  = bypass ? icache_rdata_i : head.inst;
`else
    assign push       = rsp_take;
    assign id_valid_o = ~empty;
    assign id_pc_o    = head.pc;
    assign id_inst_o  = head.inst;
`endif

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .clear (redirect_i),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pc_we_o   = 1'b0;
        pc_next_o = pc_i;
        if (rst_n) begin
            if (redirect_i) begin
                pc_we_o   = 1'b1;
                pc_next_o = redirect_pc_i;
            end else if (fire) begin
                pc_we_o   = 1'b1;
                pc_next_o = pc_i + PC_W'(PC_INC);
            end
        end
    end

    // A response arriving in S_KILL always retires the killed request, redirect or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_REQ;
            req_pc <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (fire) begin
                        state  <= S_WAIT;
                        req_pc <= pc_i;
                    end
                end
                S_WAIT: begin
                    if (icache_rvalid_i) begin
                        state <= S_REQ;
                    end else if (redirect_i) begin
                        state <= S_KILL;
                    end
                end
                S_KILL: begin
                    if (icache_rvalid_i) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a bench-side PC register and hand-driven icache handshakes.
// Build with +define+IFETCH_BYPASS_EN to check the bypass path instead of the registered path.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic [31:0] inst_b;
    logic [31:0] pc_c;
    logic        req_seen;
    logic        we_seen;

    always #5 clk = ~clk;

    ifetch_unit #(.PC_W(32), .INST_W(32), .DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_i            (pc_i),
        .pc_next_o       (pc_next),
        .pc_we_o         (pc_we),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .icache_req_o    (req),
        .icache_addr_o   (addr),
        .icache_ack_i    (ack),
        .icache_rvalid_i (rvalid),
        .icache_rdata_i  (rdata),
        .id_valid_o      (id_valid),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_ready_i      (ready)
    );

    // PC register model
    always_ff @(posedge clk) begin
        if (!rst_n) pc_i <= 32'h0;
        else if (pc_we) pc_i <= pc_next;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req;
        int n = 0;
        #1;
        while (!req && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (!req) chk("req_timeout", 64'(req), 64'h1);
    endtask

    task automatic fetch(input logic [31:0] data);
        wait_req();
        ack = 1'b1;
        tick();
        ack    = 1'b0;
        rvalid = 1'b1;
        rdata  = data;
        tick();
        rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ack = 1'b0; rvalid = 1'b0; rdata = '0;
        redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
        repeat (2) tick();
        #1;
        chk("rst_req", 64'(req), 64'h0);
        chk("rst_pc_we", 64'(pc_we), 64'h0);
        chk("rst_id_valid", 64'(id_valid), 64'h0);
        chk("rst_id_pc", 64'(id_pc), 64'h0);
        chk("rst_id_inst", 64'(id_inst), 64'h0);
        chk("rst_pc_next", 64'(pc_next), 64'h0);

        // first fetch: req in cycle 1, data on cycle 2, decode sees it on cycle 3
        rst_n = 1'b1;
        #1;
        chk("c1_req", 64'(req), 64'h1);
        chk("c1_addr", 64'(addr), 64'h0);
        ack = 1'b1;
        #1;
        chk("c1_pc_we", 64'(pc_we), 64'h1);
        chk("c1_pc_next", 64'(pc_next), 64'h4);
        tick();
        ack = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
        #1;
        chk("c2_wait_noreq", 64'(req), 64'h0);
`ifdef IFETCH_BYPASS_EN
        chk("c2_byp_valid", 64'(id_valid), 64'h1);
        chk("c2_byp_pc", 64'(id_pc), 64'h0);
        chk("c2_byp_inst", 64'(id_inst), 64'h13);
`else
        chk("c2_no_valid", 64'(id_valid), 64'h0);
`endif
        tick();
        rvalid = 1'b0;
        #1;
`ifdef IFETCH_BYPASS_EN
        chk("c3_byp_not_pushed", 64'(id_valid), 64'h0);
`else
        chk("c3_valid", 64'(id_valid), 64'h1);
        chk("c3_pc", 64'(id_pc), 64'h0);
        chk("c3_inst", 64'(id_inst), 64'h13);
`endif
        ready = 1'b0;

        // decode stalls: buffer fills to DEPTH and fetching stops
`ifdef IFETCH_BYPASS_EN
        fetch(32'h0000_0017);
        fetch(32'h0000_001b);
        pc_a = 32'h4; pc_b = 32'h8; inst_b = 32'h1b; pc_c = 32'hC;
`else
        fetch(32'h0000_0017);
        pc_a = 32'h0; pc_b = 32'h4; inst_b = 32'h17; pc_c = 32'h8;
`endif
        req_seen = 1'b0; we_seen = 1'b0;
        repeat (10) begin
            tick();
            #1;
            if (req) req_seen = 1'b1;
            if (pc_we) we_seen = 1'b1;
        end
        chk("full_no_req", 64'(req_seen), 64'h0);
        chk("full_no_pc_we", 64'(we_seen), 64'h0);
        chk("full_head_pc", 64'(id_pc), 64'(pc_a));
        ready = 1'b1;
        tick();
        #1;
        chk("pop1_pc", 64'(id_pc), 64'(pc_b));
        chk("pop1_inst", 64'(id_inst), 64'(inst_b));
        tick();
        #1;
        chk("drained", 64'(id_valid), 64'h0);
        chk("refill_req", 64'(req), 64'h1);
        chk("refill_addr", 64'(addr), 64'(pc_c));
        tick();
        #1;
        chk("hold_req", 64'(req), 64'h1);
        chk("hold_addr", 64'(addr), 64'(pc_c));
        chk("hold_no_we", 64'(pc_we), 64'h0);

        // redirect while waiting: late response is dropped
        ack = 1'b1;
        tick();
        ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("rd_pc_we", 64'(pc_we), 64'h1);
        chk("rd_pc_next", 64'(pc_next), 64'h100);
        chk("rd_no_req", 64'(req), 64'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk("kill_no_req", 64'(req), 64'h0);
        tick();
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        chk("kill_no_valid", 64'(id_valid), 64'h0);
        tick();
        rvalid = 1'b0;
        #1;
        chk("kill_dropped", 64'(id_valid), 64'h0);
        chk("kill_next_req", 64'(req), 64'h1);
        chk("kill_next_addr", 64'(addr), 64'h100);

        // redirect coincident with response, one entry buffered
        ready = 1'b0;
        fetch(32'h0000_0033);
        wait_req();
        ack = 1'b1;
        tick();
        ack = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0044;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("co_pc_we", 64'(pc_we), 64'h1);
        chk("co_pc_next", 64'(pc_next), 64'hFFFF_FFFC);
        chk("co_pre_valid", 64'(id_valid), 64'h1);
        tick();
        rvalid = 1'b0; redirect = 1'b0;
        #1;
        chk("co_cleared", 64'(id_valid), 64'h0);
        chk("co_req", 64'(req), 64'h1);
        chk("co_addr", 64'(addr), 64'hFFFF_FFFC);

        // PC increment wraps
        ack = 1'b1;
        #1;
        chk("wrap_pc_we", 64'(pc_we), 64'h1);
        chk("wrap_pc_next", 64'(pc_next), 64'h0);
        tick();
        ack = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0055;
        #1;
`ifdef IFETCH_BYPASS_EN
        chk("wrap_byp_valid", 64'(id_valid), 64'h1);
        chk("wrap_byp_pc", 64'(id_pc), 64'hFFFF_FFFC);
`endif
        tick();
        rvalid = 1'b0;
        #1;
        chk("wrap_valid", 64'(id_valid), 64'h1);
        chk("wrap_id_pc", 64'(id_pc), 64'hFFFF_FFFC);
        chk("wrap_id_inst", 64'(id_inst), 64'h55);
        chk("wrap_addr", 64'(addr), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
